// File: rtl/pkt_dispatch.sv
// pkt_dispatch: queued packet-descriptor dispatcher with per-destination done handshake.
// Define PKTDISP_TIMEOUT_EN to add the WAIT watchdog (TIMEOUT_CYC) and timeout pulse.
module pkt_dispatch #(
    parameter int ID_WIDTH    = 16,
    parameter int TYPE_WIDTH  = 3,
    parameter int NUM_DEST    = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter logic [NUM_DEST*(2**TYPE_WIDTH)-1:0] ROUTE_MAP = 32'h099A1C6A,
    parameter logic [ID_WIDTH-1:0] BCAST_ID = 16'hFFFF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  newpkt,
    input  logic [TYPE_WIDTH-1:0] fPktType,
    input  logic [ID_WIDTH-1:0]   destinationID,
    input  logic [ID_WIDTH-1:0]   myNodeID,
    input  logic [NUM_DEST-1:0]   done,
    output logic [NUM_DEST-1:0]   en_out,
    output logic                  iAmDestination,
    output logic                  iAmBroadcast,
    output logic [TYPE_WIDTH-1:0] cur_type,
    output logic                  busy,
    output logic                  full,
    output logic [7:0]            drop_cnt,
    output logic                  timeout
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = TYPE_WIDTH + ID_WIDTH;
    localparam int NT = 2**TYPE_WIDTH;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pkt_dispatch: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("pkt_dispatch: TIMEOUT_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        WAIT
    } state_t;

    state_t state;

    logic [DW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    logic [TYPE_WIDTH-1:0] head_type;
    logic [ID_WIDTH-1:0]   head_id;
    logic [NUM_DEST-1:0]   head_mask;
    logic [NUM_DEST-1:0]   route_tbl [NT];

    logic [NUM_DEST-1:0]   mask;
    logic [NUM_DEST-1:0]   pending;
    logic [NUM_DEST-1:0]   disp_left;
    logic [NUM_DEST-1:0]   wait_left;

`ifdef PKTDISP_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_cnt;
`endif

    // Reshape the flat routing map into one mask per packet type.
    for (genvar t = 0; t < NT; t++) begin : g_map
        assign route_tbl[t] = ROUTE_MAP[t*NUM_DEST +: NUM_DEST];
    end

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = newpkt && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;

    assign {head_type, head_id} = mem[rd_ptr];
    assign head_mask = route_tbl[head_type];

    assign disp_left = mask & ~done;
    assign wait_left = pending & ~done;

    assign full = fifo_full;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {fPktType, destinationID};
        end
    end

    // A push is judged against the pre-pop count, so a full FIFO drops
    // even when the head is popped in the same cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (newpkt && fifo_full && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= IDLE;
            mask           <= '0;
            pending        <= '0;
            en_out         <= '0;
            cur_type       <= '0;
            iAmDestination <= 1'b0;
            iAmBroadcast   <= 1'b0;
`ifdef PKTDISP_TIMEOUT_EN
            wait_cnt       <= '0;
            timeout        <= 1'b0;
`endif
        end else begin
            en_out <= '0;
`ifdef PKTDISP_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pop) begin
                        mask           <= head_mask;
                        en_out         <= head_mask;
                        cur_type       <= head_type;
                        iAmDestination <= (head_id == myNodeID);
                        iAmBroadcast   <= (head_id == BCAST_ID);
                        state          <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    pending <= disp_left;
`ifdef PKTDISP_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= (disp_left == '0) ? IDLE : WAIT;
                end
                WAIT: begin
                    pending <= wait_left;
                    if (wait_left == '0) begin
                        state <= IDLE;
                    end
`ifdef PKTDISP_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        pending <= '0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef PKTDISP_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/pkt_dispatch.md
Name: pkt_dispatch

Overview:
- Parametrised successor to the packet-type filter.
- Queues incoming packet descriptors (type, destinationID) in a small FIFO.
- Decodes each descriptor through a parameter-defined routing map into NUM_DEST one-cycle enable pulses.
- Holds the decision until every enabled downstream block returns done, so back-to-back packets are never lost while a block is busy.
- Sits between the packet receiver and QTableUpdate / myNodeInfo / knownCH / reward.

Parameters:
- ID_WIDTH, 16, width of node IDs.
- TYPE_WIDTH, 3, width of fPktType.
- NUM_DEST, 4, number of downstream enables. Default bit order: 0=QTU, 1=MNI, 2=KCH, 3=reward.
- FIFO_DEPTH, 4, descriptor queue depth; power of two, >=2.
- ROUTE_MAP, 32'h099A1C6A, NUM_DEST bits per type, type 0 in the LSBs. Default masks per type: 000→1010, 001→0110, 010→1100, 011→0001, 100→1010, 101→1001, 110→1001, 111→0000.
- BCAST_ID, 16'hFFFF, broadcast destination ID.
- TIMEOUT_CYC, 255, WAIT watchdog limit; used only with the optional feature.

Ports:
- clk, input, 1, clock.
- nrst, input, 1, asynchronous active-low reset.
- newpkt, input, 1, descriptor valid, sampled at posedge.
- fPktType, input, TYPE_WIDTH, packet type.
- destinationID, input, ID_WIDTH, packet destination.
- myNodeID, input, ID_WIDTH, own ID, compared at dispatch time.
- done, input, NUM_DEST, per-destination completion pulse or level.
- en_out, output, NUM_DEST, one-cycle enable pulses.
- iAmDestination, output, 1, popped destinationID == myNodeID.
- iAmBroadcast, output, 1, popped destinationID == BCAST_ID.
- cur_type, output, TYPE_WIDTH, type of the descriptor being dispatched.
- busy, output, 1, state != IDLE.
- full, output, 1, FIFO full.
- drop_cnt, output, 8, saturating count of dropped descriptors.
- timeout, output, 1, one-cycle pulse; optional-feature only, otherwise tied 0.

Behaviour:
- Reset: asynchronous, nrst low. FIFO pointers/count cleared; state=IDLE. All outputs 0: en_out, iAmDestination, iAmBroadcast, cur_type, busy, full, drop_cnt, timeout. Pending mask cleared. Reset mid-WAIT discards the in-flight descriptor and all queued ones.
- FIFO push: newpkt=1 and not full → write {fPktType, destinationID}.
- FIFO drop: newpkt=1 while full → descriptor dropped, drop_cnt+1, saturating at 255. A pop in the same cycle does not rescue the push.
- Simultaneous push and pop when not full: both occur; count unchanged.
- full is asserted when count == FIFO_DEPTH.
- State machine: IDLE, DISPATCH, WAIT.
  - IDLE: FIFO non-empty → pop the head and register cur_type, mask = ROUTE_MAP slice, iAmDestination and iAmBroadcast (myNodeID sampled at this edge); go to DISPATCH.
  - DISPATCH (1 cycle): en_out = mask, all other cycles 0. pending = mask & ~done. If pending is zero (including mask 0000) go to IDLE, else go to WAIT.
  - WAIT: each cycle pending &= ~done. Go to IDLE on the cycle pending becomes 0.
- done bits outside the mask are ignored. done in the DISPATCH cycle counts.
- iAmDestination, iAmBroadcast and cur_type hold from pop until the next pop. They are not cleared in IDLE.
- Latency, empty FIFO: newpkt sampled at edge N → pop at edge N+1 → en_out high between edges N+1 and N+2.
- Minimum throughput: one descriptor per 2 cycles (IDLE, DISPATCH) when done returns in the DISPATCH cycle.
- Equal IDs: when myNodeID == BCAST_ID, both flags may be set.

Optional Feature:
- Macro: PKTDISP_TIMEOUT_EN.
- Defined: an 8-bit WAIT cycle counter, cleared on entering WAIT. At TIMEOUT_CYC cycles in WAIT:
  - pending is cleared;
  - timeout pulses 1 cycle;
  - state goes to IDLE.
- Undefined: no counter. WAIT lasts until all done bits are seen; timeout is constant 0.

Test Plan:
- Reset with no traffic → all outputs 0.
- newpkt, type 000, dest=myNodeID=16'h0005, done=1111 held → en_out=1010 for exactly one cycle, 2 cycles after newpkt; iAmDestination=1; busy back to 0 next cycle.
- Type 010 with done withheld: done[2] pulses 3 cycles later, done[3] pulses 6 cycles later → busy stays 1 until the done[3] cycle, then IDLE; a second queued descriptor dispatches the cycle after.
- Hold done=0, send 6 descriptors (type 101) → first popped, FIFO fills at 4, 1 dropped (drop_cnt=1), full=1. Release done → all 5 remaining dispatch in order.
- Type 111, dest=16'hFFFF → en_out stays 0000, iAmBroadcast=1, returns to IDLE without waiting.
- With PKTDISP_TIMEOUT_EN defined and TIMEOUT_CYC=8: type 001, done never asserted → timeout pulses after 8 WAIT cycles and busy drops. Assert nrst low mid-WAIT → immediate return to reset values.
